countdown_timer: RTL
====================

# countdown_timer

Countdown counterpart to the stopwatch on the DE1-SOC board: it loads a preset mm:ss.cc value from switch-mapped BCD inputs and counts down in 10 ms steps to 00:00.00. Start/pause and load are controlled from debounced board keys, and expiry raises an alarm LED. The block outputs six BCD digits; the existing `sevenseg` decoders in the top level drive hex5..hex0.

## Interface
- `TICK_CYCLES`, default 500000: clk cycles per 10 ms step (50 MHz).
- `DEBOUNCE_CYCLES`, default 255: consecutive stable samples required to accept a key level change.
- `clk`  in  1  50 MHz board clock; sole clock.
- `key_reset`  in  1  asynchronous, active-high reset; the top level inverts the active-low KEY pin.
- `key_start_pause`  in  1  raw board key, active-low, asynchronous to clk.
- `key_load`  in  1  raw board key, active-low, asynchronous to clk.
- `preset_min_high`, `preset_min_low`, `preset_sec_high`, `preset_sec_low`  in  4 each  preset BCD digits. Hundredths always load as 00.
- `minute_high`, `minute_low`, `second_high`, `second_low`, `csecond_high`, `csecond_low`  out  4 each  current count, BCD.
- `led_run`  out  1  high in RUN.
- `led_done`  out  1  high in DONE.
- `done_pulse`  out  1  one-cycle strobe on expiry.

## Operation
- Reset, asynchronous: state IDLE, all six digits 0, tick counter 0, `led_run`/`led_done`/`done_pulse` 0. Debounce counters are 0, accepted key levels are 1 (released), and synchronizer flops are 1.
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce: 9-bit counter increments while the synced level differs from the accepted level and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the accepted level flips and the counter clears.
  - A 1→0 flip of the accepted level is a press event, one cycle wide. Release produces no event.
- States: IDLE, RUN, PAUSE, DONE.
- Load press:
  - In IDLE, PAUSE or DONE: digits ← preset, hundredths ← 00, tick counter ← 0, state → IDLE, `led_done` ← 0.
  - Ignored in RUN.
- Preset clamping: `preset_sec_high` > 5 loads as 5. Any other preset digit > 9 loads as 9.
- Start/pause press:
  - IDLE → RUN if the count is nonzero. IDLE with count 00:00.00 stays IDLE.
  - RUN → PAUSE.
  - PAUSE → RUN.
  - Ignored in DONE.
- Simultaneous press events: load is evaluated first. Start/pause acts on the post-load state in the same cycle, so in PAUSE with both pressed the block loads and then starts RUN.
- Tick counter:
  - RUN: increments every cycle. At `TICK_CYCLES-1` it wraps to 0 and issues one step.
  - PAUSE: holds its value, so resume keeps the phase.
  - IDLE and DONE: held at 0.
- Step, BCD decrement with borrow chain: csecond_low 0→9 borrows from csecond_high; 0→9 borrows from second_low; 0→9 borrows from second_high; 0→5 borrows from minute_low; 0→9 borrows from minute_high.
- Expiry: the step that produces 00:00.00 also moves the state to DONE, with the digits at 0.
- Underflow past 00:00.00 never occurs.
- Digit outputs and LEDs are registered.

## Timing
- Key latency: a raw level held stable produces the press event 2 + `DEBOUNCE_CYCLES` cycles after the level change. The FSM updates on the next edge.
- Glitches shorter than `DEBOUNCE_CYCLES` samples produce no event.
- Step period in RUN: exactly `TICK_CYCLES` clk. The first step occurs `TICK_CYCLES` cycles after the RUN entry edge.
- Expiry:
  - Digits read 0, `led_done`=1, `led_run`=0, and `done_pulse`=1, all registered on the same edge.
  - `done_pulse` returns to 0 on the following edge.
- Start/pause presses: `led_run` follows the state on the same edge as the transition.
- Reset asserted mid-count: all outputs go to their reset values immediately, without waiting for clk. After reset deasserts, the first press is accepted only after a full debounce.

## Test plan
Benches use `TICK_CYCLES`=4 and `DEBOUNCE_CYCLES`=3.
- Reset and load: reset; preset 0,1,3,0; load press → digits 01:30.00, IDLE, all LEDs 0.
- Countdown with borrow:
  - Preset 00:01, start → 00:00.99 after 4 cycles and 00:00.98 after 8.
  - After 100 steps → 00:00.00, `led_done`=1, one-cycle `done_pulse`.
- Pause/resume: pause between steps (tick counter mid-phase), hold 20 cycles, resume → digits unchanged during PAUSE. The next step arrives after the remaining tick cycles only.
- Debounce: a 2-cycle low glitch on `key_start_pause` produces no state change; a 5-cycle-stable low starts RUN.
- Boundaries:
  - Start with count 0 stays IDLE.
  - Load in RUN is ignored.
  - Preset 9,9,7,9 with sec_high clamped → 99:59.00.
  - 10:00.00 after one step → 09:59.99.
- Async reset mid-RUN: assert `key_reset` between edges → digits 0 and `led_run`=0 before the next clk edge.

Source files
------------

// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
// countdown_timer: mm:ss.cc countdown driven by two debounced board keys.
// Loads a clamped BCD preset, counts down in fixed tick steps and
// raises an alarm (led_done plus a one-cycle done_pulse) on reaching zero.

// ---------------------------------------------------------------------------
// countdown_key: synchronizer + debouncer for one active-low board key.
// press_o is a one-cycle pulse when the accepted level falls from 1 to 0.
// ---------------------------------------------------------------------------
module countdown_key #(
    parameter int DEBOUNCE_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic press_o
);
    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic [8:0] cnt_q;
    logic [8:0] cnt_d;
    logic       press_q;
    logic       press_d;

    // Two-flop synchronizer; a released key idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count samples that disagree with the accepted level; flip once enough
    // consecutive disagreeing samples have been seen.
    always_comb begin
        level_d = level_q;
        cnt_d   = 9'd0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == 9'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end
    end

    // Debounce state and registered press strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b1;
            cnt_q   <= 9'd0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

// ---------------------------------------------------------------------------
// countdown_timer top
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int TICK_CYCLES     = 500000,
    parameter int DEBOUNCE_CYCLES = 255
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_load,
    input  logic [3:0] preset_min_high,
    input  logic [3:0] preset_min_low,
    input  logic [3:0] preset_sec_high,
    input  logic [3:0] preset_sec_low,
    output logic [3:0] minute_high,
    output logic [3:0] minute_low,
    output logic [3:0] second_high,
    output logic [3:0] second_low,
    output logic [3:0] csecond_high,
    output logic [3:0] csecond_low,
    output logic       led_run,
    output logic       led_done,
    output logic       done_pulse
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t post_load_state;

    // Digit index 0 is csecond_low, index 5 is minute_high.
    logic [3:0]        digit_q [6];
    logic [3:0]        digit_d [6];
    logic [3:0]        digit_dec [6];
    logic [3:0]        preset_raw [6];
    logic [3:0]        preset_clamped [6];
    logic [6:0]        borrow;
    logic [5:0]        cur_nz;
    logic [5:0]        dec_nz;
    logic [5:0]        pre_nz;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              load_take;
    logic              post_load_zero;
    logic              done_pulse_d;
    logic              done_pulse_q;
    logic              led_run_q;
    logic              led_done_q;
    logic [1:0]        key_raw;
    logic [1:0]        key_press;
    logic              start_evt;
    logic              load_evt;

    // Key paths: index 0 is start/pause, index 1 is load.
    assign key_raw = {key_load, key_start_pause};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            countdown_key #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk      (clk),
                .rst      (key_reset),
                .key_raw_i(key_raw[gi]),
                .press_o  (key_press[gi])
            );
        end
    endgenerate

    assign start_evt = key_press[0];
    assign load_evt  = key_press[1];

    // Hundredths always load as zero.
    assign preset_raw[0] = 4'd0;
    assign preset_raw[1] = 4'd0;
    assign preset_raw[2] = preset_sec_low;
    assign preset_raw[3] = preset_sec_high;
    assign preset_raw[4] = preset_min_low;
    assign preset_raw[5] = preset_min_high;

    // Per-digit clamp, BCD decrement with borrow chain, and nonzero flags.
    // Tens-of-seconds rolls over to 5; every other digit rolls over to 9.
    assign borrow[0] = 1'b1;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = (gi == 3) ? 4'd5 : 4'd9;

            assign preset_clamped[gi] = (preset_raw[gi] > LIMIT) ? LIMIT : preset_raw[gi];

            assign digit_dec[gi] = !borrow[gi]          ? digit_q[gi] :
                                   (digit_q[gi] == 4'd0) ? LIMIT :
                                                           digit_q[gi] - 4'd1;
            assign borrow[gi + 1] = borrow[gi] & (digit_q[gi] == 4'd0);

            assign cur_nz[gi] = |digit_q[gi];
            assign dec_nz[gi] = |digit_dec[gi];
            assign pre_nz[gi] = |preset_clamped[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, digits and tick counter. Load is resolved first and the
    // start/pause key then acts on the post-load state of the same cycle.
    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        done_pulse_d    = 1'b0;
        load_take       = 1'b0;
        post_load_state = state_q;
        post_load_zero  = ~|cur_nz;
        for (int i = 0; i < 6; i++) begin
            digit_d[i] = digit_q[i];
        end

        if (load_evt && (state_q != ST_RUN)) begin
            load_take       = 1'b1;
            post_load_state = ST_IDLE;
            post_load_zero  = ~|pre_nz;
            for (int i = 0; i < 6; i++) begin
                digit_d[i] = preset_clamped[i];
            end
        end

        state_d = post_load_state;
        if (start_evt) begin
            case (post_load_state)
                ST_IDLE:  if (!post_load_zero) state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = post_load_state;
            endcase
        end

        // The tick phase advances on every cycle spent in RUN, including the
        // cycle in which a pause is accepted, and is kept while paused.
        case (state_q)
            ST_RUN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    for (int i = 0; i < 6; i++) begin
                        digit_d[i] = digit_dec[i];
                    end
                    if (~|dec_nz) begin
                        state_d      = ST_DONE;
                        done_pulse_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_PAUSE: tick_d = load_take ? '0 : tick_q;
            default:  tick_d = '0;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            for (int i = 0; i < 6; i++) begin
                digit_q[i] <= 4'd0;
            end
            tick_q       <= '0;
            led_run_q    <= 1'b0;
            led_done_q   <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                digit_q[i] <= digit_d[i];
            end
            tick_q       <= tick_d;
            led_run_q    <= (state_d == ST_RUN);
            led_done_q   <= (state_d == ST_DONE);
            done_pulse_q <= done_pulse_d;
        end
    end

    assign csecond_low  = digit_q[0];
    assign csecond_high = digit_q[1];
    assign second_low   = digit_q[2];
    assign second_high  = digit_q[3];
    assign minute_low   = digit_q[4];
    assign minute_high  = digit_q[5];
    assign led_run      = led_run_q;
    assign led_done     = led_done_q;
    assign done_pulse   = done_pulse_q;
endmodule
